// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and counter-width helper for serial_adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ceiling log2; clog2(n) bits hold any value 0..n-1.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: one-bit combinational full adder used by serial_adder.
// Ports: a, b, ci - addend bits and carry-in; s - sum bit; co - carry-out.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor, one result bit per clock, LSB first.
// Ports: clk, rst (sync, active-high); start/sub/a/b/cin request an operation
// (sampled only in IDLE); sum/cout hold the last result; busy is high in RUN
// and DONE; done pulses once per completed operation.
// Optional: define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = clog2(WIDTH + 1);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-2:0] r_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             bit_s;
   logic             bit_co;
   logic             last_c;
   logic [WIDTH-1:0] r_nx_c;

   // Single full-adder cell working on the current LSBs and the carry register.
   fa_cell u_fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (carry),
      .s  (bit_s),
      .co (bit_co)
   );

   assign last_c = (cnt == CW'(WIDTH - 1));
   // New bit enters at the MSB; after WIDTH shifts this is the full result.
   assign r_nx_c = {bit_s, r_sr};

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last_c) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         r_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         busy  <= (state_nx != IDLE);
         // Pulse lags the DONE state by one cycle, giving WIDTH+1 latency.
         done  <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               r_sr  <= r_nx_c[WIDTH-1:1];
               carry <= bit_co;
               cnt   <= cnt + CW'(1);
               if (last_c) begin
                  sum  <= r_nx_c;
                  cout <= bit_co;
`ifdef SERIAL_ADDER_OVF_EN
                  // Carry into MSB is the carry register during the MSB cycle.
                  ovf  <= carry ^ bit_co;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed self-checking bench for serial_adder (WIDTH=8).
// Inputs are driven and outputs sampled on the falling edge. For an operation whose
// start is taken at rising edge t, falling edge k is the one after rising edge t+k-1,
// so done is expected at k = W+2 and busy is high for W+1 of those samples.
module tb_serial_adder;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
   logic         done;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int n_cmp;
   int n_bad;
   logic [W-1:0] last_sum;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sum   (sum),
      .cout  (cout),
      .busy  (busy),
      .done  (done)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic from the operation definition.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                        input logic mcin, output logic [W-1:0] es, output logic ec,
                        output logic eo);
      int ua, ub, sa, sb, t, r;
      ua = int'(ma);
      ub = int'(mb);
      sa = ua - ((ua >= (1 << (W-1))) ? (1 << W) : 0);
      sb = ub - ((ub >= (1 << (W-1))) ? (1 << W) : 0);
      if (msub) begin
         t  = ua - ub;
         ec = (ua >= ub);
         r  = sa - sb;
      end else begin
         t  = ua + ub + int'(mcin);
         ec = (t >= (1 << W));
         r  = sa + sb + int'(mcin);
      end
      es = W'(t);
      eo = (r > ((1 << (W-1)) - 1)) || (r < -(1 << (W-1)));
   endtask

   // Drives one operation and reports what the DUT did; checks are made by callers.
   task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic osub,
                        input logic ocin, input bit noise, input int inj_k,
                        input logic [W-1:0] prev, output int lat, output int busy_n,
                        output logic [W-1:0] rs, output logic rc, output logic ro,
                        output bit stable);
      @(negedge clk);
      a = oa; b = ob; sub = osub; cin = ocin; start = 1'b1;
      lat = 0; busy_n = 0; stable = 1'b1; rs = '0; rc = 1'b0; ro = 1'b0;
      for (int k = 1; k <= int'(W) + 6 && lat == 0; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) busy_n++;
         if (k <= int'(W) && sum !== prev) stable = 1'b0;
         if (done === 1'b1) begin
            lat = k; rs = sum; rc = cout;
`ifdef SERIAL_ADDER_OVF_EN
            ro = ovf;
`endif
         end else begin
            if (noise) begin
               a = W'($urandom); b = W'($urandom);
               sub = 1'($urandom); cin = 1'($urandom);
               start = (k <= int'(W) + 1) ? 1'($urandom) : 1'b0;
            end
            if (k == inj_k) begin
               start = 1'b1; a = W'($urandom); b = W'($urandom);
               sub = 1'($urandom); cin = 1'($urandom);
            end
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a = 8'hA5; b = 8'h3C; sub = 1'b0; cin = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b, required all zero",
                  busy, done, sum, cout);
      end
`ifdef SERIAL_ADDER_OVF_EN
      n_cmp++;
      if (ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ovf: got %b, required 0", ovf);
      end
`endif
      start = 1'b0;
      rst = 1'b0;
      last_sum = '0;
   endtask

   task automatic check_op(input string name, input logic [W-1:0] oa, input logic [W-1:0] ob,
                           input logic osub, input logic ocin, input bit noise, input int inj_k);
      int lat, busy_n;
      logic [W-1:0] rs, es;
      logic rc, ro, ec, eo;
      bit stable;
      model(oa, ob, osub, ocin, es, ec, eo);
      do_op(oa, ob, osub, ocin, noise, inj_k, last_sum, lat, busy_n, rs, rc, ro, stable);
      n_cmp++;
      if (lat !== int'(W) + 2) begin
         n_bad++;
         $display("FAIL %s latency: done at sample %0d, required %0d", name, lat, W + 2);
      end
      n_cmp++;
      if (busy_n !== int'(W) + 1) begin
         n_bad++;
         $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_n, W + 1);
      end
      n_cmp++;
      if (rs !== es || rc !== ec) begin
         n_bad++;
         $display("FAIL %s result: a=%h b=%h sub=%b cin=%b got sum=%h cout=%b, required sum=%h cout=%b",
                  name, oa, ob, osub, ocin, rs, rc, es, ec);
      end
`ifdef SERIAL_ADDER_OVF_EN
      n_cmp++;
      if (ro !== eo) begin
         n_bad++;
         $display("FAIL %s ovf: got %b, required %b", name, ro, eo);
      end
`endif
      n_cmp++;
      if (!stable) begin
         n_bad++;
         $display("FAIL %s sum_hold_in_run: sum changed during RUN, required %h", name, last_sum);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || sum !== es) begin
         n_bad++;
         $display("FAIL %s after_done: done=%b sum=%h, required done=0 sum=%h", name, done, sum, es);
      end
      last_sum = es;
   endtask

   task automatic test_directed();
      check_op("add_200_100", 8'd200, 8'd100, 1'b0, 1'b0, 1'b0, 0);
      check_op("sub_5_7",     8'd5,   8'd7,   1'b1, 1'b0, 1'b0, 0);
      check_op("add_7f_01",   8'h7F,  8'h01,  1'b0, 1'b0, 1'b0, 0);
      check_op("add_ff_cin",  8'hFF,  8'h00,  1'b0, 1'b1, 1'b0, 0);
      check_op("sub_cin_ign", 8'h80,  8'h01,  1'b1, 1'b1, 1'b0, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++)
         check_op("random", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1, 0);
   endtask

   task automatic test_ignore_start();
      check_op("ignore_first",  8'h33, 8'h44, 1'b0, 1'b1, 1'b0, 3);
      check_op("ignore_second", 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 0);
   endtask

   task automatic test_reset_abort();
      int seen;
      @(negedge clk);
      a = 8'h5A; b = 8'h21; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || sum !== '0 || done !== 1'b0 || cout !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_state: busy=%b sum=%h done=%b cout=%b, required 0/00/0/0",
                  busy, sum, done, cout);
      end
      seen = 0;
      for (int k = 0; k < int'(W) + 4; k++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_bad++;
         $display("FAIL abort_no_done: %0d cycles with done/busy high, required 0", seen);
      end
      last_sum = '0;
      check_op("after_abort", 8'h5A, 8'h21, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a1, b1, a2, b2, e1, e2, s1, s2;
      logic u1, u2, c1, c2, ec1, ec2, eo1, eo2, bz;
      int d1, d2;
      a1 = W'($urandom); b1 = W'($urandom); u1 = 1'($urandom); c1 = 1'($urandom);
      a2 = W'($urandom); b2 = W'($urandom); u2 = 1'($urandom); c2 = 1'($urandom);
      model(a1, b1, u1, c1, e1, ec1, eo1);
      model(a2, b2, u2, c2, e2, ec2, eo2);
      d1 = 0; d2 = 0; s1 = '0; s2 = '0; bz = 1'b1;
      @(negedge clk);
      a = a1; b = b1; sub = u1; cin = c1; start = 1'b1;
      for (int k = 1; k <= 2 * int'(W) + 8 && d2 == 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            a = a2; b = b2; sub = u2; cin = c2;
         end
         if (done === 1'b1) begin
            if (d1 == 0) begin
               d1 = k; s1 = sum; bz = busy;
            end else begin
               d2 = k; s2 = sum; start = 1'b0;
            end
         end
      end
      start = 1'b0;
      n_cmp++;
      if (d1 != int'(W) + 2 || d2 != 2 * int'(W) + 4) begin
         n_bad++;
         $display("FAIL b2b_timing: done at %0d,%0d, required %0d,%0d", d1, d2, W + 2, 2 * W + 4);
      end
      n_cmp++;
      if (s1 !== e1 || s2 !== e2) begin
         n_bad++;
         $display("FAIL b2b_results: got %h,%h, required %h,%h", s1, s2, e1, e2);
      end
      n_cmp++;
      if (bz !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_idle_gap: busy=%b at first done, required 0", bz);
      end
      @(negedge clk);
      last_sum = e2;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; last_sum = '0;
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port sub  input  1  0 = a+b+cin, 1 = a-b; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port cin  input  1  carry-in for add; ignored when sub=1.
REQ-009 SHALL have port sum  output  WIDTH  result; valid from the done pulse until the next accepted start.
REQ-010 SHALL have port cout  output  1  final carry; for subtract, 1 = no borrow.
REQ-011 SHALL have port busy  output  1  high in RUN and DONE.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-013 SHALL have port ovf  output  1  signed overflow flag; present only with SERIAL_ADDER_OVF_EN.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
- IDLE->RUN on start=1.
- RUN->DONE after exactly WIDTH bit cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-015 SHALL, on an accepted start, latch in the same cycle:
- a;
- b, or ~b when sub=1;
- initial carry = sub ? 1 : cin;
- bit counter = 0.
REQ-016 SHALL, in each RUN cycle, add latched bit 0 of A and B with the carry register, shift the result bit in at the MSB of the result register, shift A and B right by one, update the carry register, and increment the counter.
REQ-017 SHALL use a start-to-done latency of WIDTH+1 cycles: start high at edge t gives done=1 in the cycle after edge t+WIDTH+1.
REQ-018 SHALL ignore start while busy=1, with no effect on operands, result or state.
REQ-019 SHALL ignore changes on a, b, sub and cin during RUN and DONE.
REQ-020 SHALL load sum and cout (and ovf when present) on entry to DONE, and hold them unchanged through IDLE until the next accepted start.
REQ-021 SHALL keep sum, cout and ovf at their previous values while RUN is in progress; the partial result is not visible on sum.
REQ-022 SHALL produce results modulo 2^WIDTH; cout is the carry out of bit WIDTH-1.
REQ-023 SHALL accept start=1 held continuously, beginning a new operation in each IDLE cycle, i.e. one operation every WIDTH+2 cycles.

Reset
REQ-024 SHALL, with rst=1 at a clock edge, force state IDLE, counter 0, carry 0, operand registers 0, sum 0, cout 0, busy 0, done 0, ovf 0.
REQ-025 SHALL let rst take priority over start.
REQ-026 SHALL abort a RUN in progress on rst with no done pulse; the result is discarded.

Configuration
REQ-027 SHALL, with macro SERIAL_ADDER_OVF_EN defined, provide port ovf = (carry into MSB) XOR (carry out of MSB), captured during the final RUN cycle and loaded with sum.
REQ-028 SHALL, without SERIAL_ADDER_OVF_EN, omit port ovf and its logic entirely; all other behaviour is identical.

Structure
REQ-029 SHALL take the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter-width function clog2(WIDTH+1) from shared package serial_adder_pkg.
REQ-030 SHALL instantiate exactly one combinational one-bit sub-module fa_cell (ports a, b, ci, s, co) for the per-bit sum and carry; FSM and shift registers stay in serial_adder.

Verification (WIDTH=8)
REQ-031 SHALL cover: sub=0, a=200, b=100, cin=0, start pulse -> done after 9 cycles, sum=44, cout=1; busy high for 9 cycles.
REQ-032 SHALL cover: sub=1, a=5, b=7 -> sum=0xFE, cout=0 (borrow), ovf=0 when enabled.
REQ-033 SHALL cover: sub=0, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1 (macro defined); same run without macro compiles with no ovf port.
REQ-034 SHALL cover: sub=0, a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-035 SHALL cover: second start with new operands 3 cycles into RUN -> ignored; first result delivered unchanged, then start accepted in IDLE.
REQ-036 SHALL cover: rst asserted 4 cycles into RUN -> next cycle IDLE, busy=0, sum=0, no done pulse; a fresh start then completes normally.
